// File: rtl/fetch_unit.sv
// fetch_unit: BOOT/RUN/HALTED instruction fetch stage with IF/ID register; FETCH_MISALIGN_TRAP_EN enables misaligned-redirect trap.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] HALT_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_target,
  output logic [7:0]  addy,
  input  logic [31:0] inst,
  output logic        if_valid,
  output logic [7:0]  if_pc,
  output logic [31:0] if_inst,
  output logic        halted,
  output logic        fault
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;
  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d, if_pc_q, if_pc_d, tgt;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d, fault_q, fault_d, run, fetch, misalign;
  assign run   = state_q == RUN;
  assign fetch = run && !redirect && !stall;
  assign tgt   = redirect_target & 8'hFC;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = redirect_target[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == BOOT ? RUN :
              (run && ((redirect && misalign) || (fetch && inst == HALT_INST))) ? HALTED : state_q;
  end
  always_comb begin
    halted   = state_q == HALTED;
    addy     = pc_q;
    if_valid = if_valid_q;
    if_pc    = if_pc_q;
    if_inst  = if_inst_q;
    fault    = fault_q;
  end
  // redirect beats stall; a trapped redirect leaves the PC where it was
  always_comb begin
    pc_d       = !run ? pc_q : redirect ? (misalign ? pc_q : tgt) : stall ? pc_q : pc_q + 8'd4;
    if_valid_d = run && !redirect && (stall ? if_valid_q : 1'b1);
    if_pc_d    = fetch ? pc_q : if_pc_q;
    if_inst_d  = fetch ? inst : if_inst_q;
    fault_d    = fault_q | (run && redirect && misalign);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 8'h00;
      if_inst_q  <= 32'h00000000;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      fault_q    <= fault_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit run, stall, redirect, wrap, misalign and halt behaviour.
module tb_fetch_unit;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect = 1'b0, halt_at_08 = 1'b0;
  logic [7:0]  redirect_target = 8'h00, addy, if_pc, held;
  logic [31:0] inst, if_inst;
  logic        if_valid, halted, fault;
  int          tests = 0, fails = 0;
  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .addy(addy), .inst(inst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .halted(halted), .fault(fault)
  );
  always #5 clk = ~clk;
  // ROM word is never zero except the optional halt slot at 08
  always_comb inst = (halt_at_08 && addy == 8'h08) ? 32'h00000000 : {8'hC0, addy, ~addy, addy};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
    step();
    tests++; if (addy !== 8'h00) begin fails++; $display("FAIL reset_addy got %h exp 00", addy); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    tests++; if (if_pc !== 8'h00) begin fails++; $display("FAIL reset_if_pc got %h exp 00", if_pc); end
    tests++; if (if_inst !== 32'h0) begin fails++; $display("FAIL reset_if_inst got %h exp 0", if_inst); end
    tests++; if (halted !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b exp 00", halted, fault); end
  endtask
  task automatic test_run();
    reset = 1'b0;
    step();
    tests++; if (addy !== 8'h00 || if_valid !== 1'b0) begin fails++; $display("FAIL boot_cycle got %h/%b exp 00/0", addy, if_valid); end
    step();
    tests++; if (addy !== 8'h04 || if_valid !== 1'b1) begin fails++; $display("FAIL run1 got %h/%b exp 04/1", addy, if_valid); end
    tests++; if (if_pc !== 8'h00 || if_inst !== 32'hC000FF00) begin fails++; $display("FAIL run1_ifid got %h/%h exp 00/C000FF00", if_pc, if_inst); end
    step();
    tests++; if (addy !== 8'h08 || if_pc !== 8'h04) begin fails++; $display("FAIL run2 got %h/%h exp 08/04", addy, if_pc); end
  endtask
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (addy !== 8'h08 || if_pc !== 8'h04 || if_inst !== 32'hC004FB04 || if_valid !== 1'b1) begin
        fails++; $display("FAIL stall%0d got %h/%h/%h/%b exp 08/04/C004FB04/1", i, addy, if_pc, if_inst, if_valid);
      end
    end
    stall = 1'b0;
    step();
    tests++; if (addy !== 8'h0C || if_pc !== 8'h08 || if_inst !== 32'hC008F708) begin fails++; $display("FAIL stall_release got %h/%h/%h exp 0C/08/C008F708", addy, if_pc, if_inst); end
    step();
    tests++; if (addy !== 8'h10) begin fails++; $display("FAIL stall_after got %h exp 10", addy); end
  endtask
  task automatic test_redirect();
    redirect = 1'b1; stall = 1'b1; redirect_target = 8'h20;
    step();
    tests++; if (addy !== 8'h20 || if_valid !== 1'b0) begin fails++; $display("FAIL redirect got %h/%b exp 20/0", addy, if_valid); end
    redirect = 1'b0; stall = 1'b0;
    step();
    tests++; if (addy !== 8'h24 || if_pc !== 8'h20 || if_valid !== 1'b1) begin fails++; $display("FAIL redirect_next got %h/%h/%b exp 24/20/1", addy, if_pc, if_valid); end
  endtask
  task automatic test_wrap();
    redirect = 1'b1; redirect_target = 8'hFC;
    step();
    tests++; if (addy !== 8'hFC) begin fails++; $display("FAIL wrap_load got %h exp FC", addy); end
    redirect = 1'b0;
    step();
    tests++; if (addy !== 8'h00 || if_pc !== 8'hFC || if_inst !== 32'hC0FC03FC) begin fails++; $display("FAIL wrap got %h/%h/%h exp 00/FC/C0FC03FC", addy, if_pc, if_inst); end
    tests++; if (fault !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL wrap_flags got %b%b exp 00", fault, halted); end
  endtask
  task automatic test_misalign();
    redirect = 1'b1; redirect_target = 8'h1E;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    tests++; if (fault !== 1'b1 || halted !== 1'b1 || addy !== 8'h00 || if_valid !== 1'b0) begin fails++; $display("FAIL misalign_trap got %b/%b/%h/%b exp 1/1/00/0", fault, halted, addy, if_valid); end
`else
    tests++; if (fault !== 1'b0 || halted !== 1'b0 || addy !== 8'h1C || if_valid !== 1'b0) begin fails++; $display("FAIL misalign_mask got %b/%b/%h/%b exp 0/0/1C/0", fault, halted, addy, if_valid); end
`endif
  endtask
  task automatic test_boot_redirect();
    reset = 1'b1;
    step();
    reset = 1'b0; redirect = 1'b1; redirect_target = 8'h40;
    step();
    redirect = 1'b0;
    tests++; if (addy !== 8'h00 || fault !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL boot_redirect got %h/%b/%b exp 00/0/0", addy, fault, halted); end
  endtask
  task automatic test_halt();
    reset = 1'b1; halt_at_08 = 1'b1;
    step();
    reset = 1'b0;
    step(); step(); step();
    tests++; if (addy !== 8'h08) begin fails++; $display("FAIL halt_pre got %h exp 08", addy); end
    step();
    tests++; if (if_inst !== 32'h0 || if_pc !== 8'h08 || if_valid !== 1'b1 || halted !== 1'b1) begin fails++; $display("FAIL halt_capture got %h/%h/%b/%b exp 0/08/1/1", if_inst, if_pc, if_valid, halted); end
    held = addy;
    step();
    tests++; if (if_valid !== 1'b0 || halted !== 1'b1 || addy !== held) begin fails++; $display("FAIL halted_hold got %b/%b/%h exp 0/1/%h", if_valid, halted, addy, held); end
    redirect = 1'b1; stall = 1'b1; redirect_target = 8'h40;
    step();
    tests++; if (addy !== held || halted !== 1'b1 || if_valid !== 1'b0) begin fails++; $display("FAIL halted_ignore got %h/%b/%b exp %h/1/0", addy, halted, if_valid, held); end
    reset = 1'b1; redirect = 1'b0; stall = 1'b0;
    step();
    tests++; if (addy !== 8'h00 || halted !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL halt_reset got %h/%b/%b exp 00/0/0", addy, halted, if_valid); end
    halt_at_08 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_boot_redirect();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
